sbc_uart: RTL and testbench

//  8N1 UART occupying the 16-byte I/O window selected by nCSUART (FE00-FE0F, 4 regs aliased x4).

---
 rtl/sbc_uart.sv | 232 +++++++++++++++++++++++
 tb/tb_sbc_uart.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sbc_uart.sv
// 8N1 UART in the FE00-FE0F I/O window: 1-deep TX holding register, RX FIFO,
// 6809 bus commit on the falling edge of E and a registered active-low IRQ.
module sbc_uart #(
    parameter logic [7:0] DIV_RESET = 8'd3,
    parameter int         RX_DEPTH  = 4
) (
    input  logic       CLKX4,
    input  logic       RESET,
    input  logic       E,
    input  logic       nCSUART,
    input  logic       RnW,
    input  logic [1:0] ADDR,
    input  logic [7:0] DATA_in,
    output logic [7:0] DATA_out,
    output logic       DATA_oe,
    input  logic       RXD,
    output logic       TXD,
    output logic       nIRQ
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {TX_IDLE, TX_ARM, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic       e_q_reg, hit_reg, rnw_q_reg;
    logic [1:0] addr_q_reg;
    logic [7:0] din_q_reg;
    logic [1:0] ctrl_reg;
    logic [7:0] div_reg, tick_cnt_reg;
    logic       tick, commit, wr_data, rd_data, wr_status;

    tx_state_t  tx_state_reg, tx_state_next;
    logic [3:0] tx_tcnt_reg;
    logic [2:0] tx_bit_reg;
    logic [7:0] tx_shift_reg, hold_reg;
    logic       hold_full_reg, tx_load, tx_bit_end;

    rx_state_t  rx_state_reg, rx_state_next;
    logic       rxd_s1_reg, rxd_s2_reg, rxd_s3_reg;
    logic [3:0] rx_tcnt_reg;
    logic [2:0] rx_bit_reg;
    logic [7:0] rx_shift_reg;
    logic       rx_push, rx_fe, rx_sample, rx_mid_start;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wptr_reg, rptr_reg;
    logic [CW-1:0] count_reg;
    logic          fifo_full, rxav, pop, push_ok, ovr_set;
    logic          fe_reg, ovr_reg, nirq_reg, txe, txidle, irq;

    // Bus: capture during E high, act once on the falling edge of E.
    assign commit    = e_q_reg & ~E & hit_reg;
    assign wr_data   = commit & ~rnw_q_reg & (addr_q_reg == 2'd0);
    assign rd_data   = commit &  rnw_q_reg & (addr_q_reg == 2'd0);
    assign wr_status = commit & ~rnw_q_reg & (addr_q_reg == 2'd1);

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            e_q_reg    <= 1'b0;
            hit_reg    <= 1'b0;
            rnw_q_reg  <= 1'b1;
            addr_q_reg <= 2'd0;
            din_q_reg  <= 8'd0;
            ctrl_reg   <= 2'd0;
            div_reg    <= DIV_RESET;
        end else begin
            e_q_reg <= E;
            if (E && !nCSUART) begin
                hit_reg    <= 1'b1;
                addr_q_reg <= ADDR;
                rnw_q_reg  <= RnW;
                din_q_reg  <= DATA_in;
            end else if (commit) begin
                hit_reg <= 1'b0;
            end
            if (commit && !rnw_q_reg && addr_q_reg == 2'd2) ctrl_reg <= din_q_reg[1:0];
            if (commit && !rnw_q_reg && addr_q_reg == 2'd3) div_reg  <= din_q_reg;
        end
    end

    // Free-running 16x baud tick; a new divisor is only seen at reload.
    assign tick = (tick_cnt_reg == 8'd0);
    always_ff @(posedge CLKX4) begin
        if (RESET) tick_cnt_reg <= DIV_RESET;
        else       tick_cnt_reg <= tick ? div_reg : tick_cnt_reg - 8'd1;
    end

    // Transmitter
    assign tx_bit_end = tick & (tx_tcnt_reg == 4'd15);
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            TX_IDLE:  if (hold_full_reg) begin tx_state_next = TX_ARM; tx_load = 1'b1; end
            TX_ARM:   if (tick) tx_state_next = TX_START;
            TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit_reg == 3'd7) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) begin
                          if (hold_full_reg) begin tx_state_next = TX_START; tx_load = 1'b1; end
                          else tx_state_next = TX_IDLE;
                      end
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            tx_state_reg  <= TX_IDLE;
            tx_tcnt_reg   <= 4'd0;
            tx_bit_reg    <= 3'd0;
            tx_shift_reg  <= 8'd0;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_state_reg == TX_IDLE || tx_state_reg == TX_ARM) tx_tcnt_reg <= 4'd0;
            else if (tick)                                         tx_tcnt_reg <= tx_tcnt_reg + 4'd1;
            if (tx_load) begin
                tx_shift_reg <= hold_reg;
                tx_bit_reg   <= 3'd0;
            end else if (tx_state_reg == TX_DATA && tx_bit_end) begin
                tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                tx_bit_reg   <= tx_bit_reg + 3'd1;
            end
            if (tx_load) hold_full_reg <= 1'b0;
            else if (wr_data && !hold_full_reg) begin
                hold_reg      <= din_q_reg;
                hold_full_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        case (tx_state_reg)
            TX_START: TXD = 1'b0;
            TX_DATA:  TXD = tx_shift_reg[0];
            default:  TXD = 1'b1;
        endcase
    end

    // Receiver: only a 1->0 edge arms it, so a held-low break gives a single FE.
    assign rx_sample    = tick & (rx_tcnt_reg == 4'd15);
    assign rx_mid_start = tick & (rx_tcnt_reg == 4'd7);
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_push       = 1'b0;
        rx_fe         = 1'b0;
        case (rx_state_reg)
            RX_IDLE:  if (rxd_s3_reg && !rxd_s2_reg) rx_state_next = RX_START;
            RX_START: if (rx_mid_start) rx_state_next = rxd_s2_reg ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_sample) begin
                          rx_state_next = RX_IDLE;
                          rx_push       = rxd_s2_reg;
                          rx_fe         = ~rxd_s2_reg;
                      end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            rx_state_reg <= RX_IDLE;
            rxd_s1_reg   <= 1'b1;
            rxd_s2_reg   <= 1'b1;
            rxd_s3_reg   <= 1'b1;
            rx_tcnt_reg  <= 4'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            rx_state_reg <= rx_state_next;
            rxd_s1_reg   <= RXD;
            rxd_s2_reg   <= rxd_s1_reg;
            rxd_s3_reg   <= rxd_s2_reg;
            if (rx_state_reg == RX_IDLE || (rx_state_reg == RX_START && rx_mid_start))
                rx_tcnt_reg <= 4'd0;
            else if (tick)
                rx_tcnt_reg <= rx_tcnt_reg + 4'd1;
            if (rx_state_reg != RX_DATA) rx_bit_reg <= 3'd0;
            else if (rx_sample) begin
                rx_shift_reg <= {rxd_s2_reg, rx_shift_reg[7:1]};
                rx_bit_reg   <= rx_bit_reg + 3'd1;
            end
        end
    end

    // RX FIFO; a pop frees room for a push landing in the same cycle.
    assign fifo_full = (count_reg == CW'(RX_DEPTH));
    assign rxav      = (count_reg != '0);
    assign pop       = rd_data & rxav;
    assign push_ok   = rx_push & (~fifo_full | pop);
    assign ovr_set   = rx_push & fifo_full & ~pop;

    always_ff @(posedge CLKX4) begin
        if (push_ok) fifo_mem[wptr_reg] <= rx_shift_reg;
    end

    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            fe_reg    <= 1'b0;
            ovr_reg   <= 1'b0;
            nirq_reg  <= 1'b1;
        end else begin
            if (push_ok) wptr_reg <= wptr_reg + 1'b1;
            if (pop)     rptr_reg <= rptr_reg + 1'b1;
            if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
            fe_reg   <= (fe_reg  & ~wr_status) | rx_fe;
            ovr_reg  <= (ovr_reg & ~wr_status) | ovr_set;
            nirq_reg <= ~irq;
        end
    end

    assign txe    = ~hold_full_reg;
    assign txidle = txe & (tx_state_reg == TX_IDLE);
    assign irq    = (ctrl_reg[0] & rxav) | (ctrl_reg[1] & txe);
    assign nIRQ   = nirq_reg;
    assign DATA_oe = ~nCSUART & RnW;

    always_comb begin
        case (ADDR)
            2'd0:    DATA_out = rxav ? fifo_mem[rptr_reg] : 8'h00;
            2'd1:    DATA_out = {irq, 2'b00, ovr_reg, fe_reg, txidle, txe, rxav};
            2'd2:    DATA_out = {6'b0, ctrl_reg};
            default: DATA_out = div_reg;
        endcase
    end
endmodule

// File: tb/tb_sbc_uart.sv
// Directed bench for sbc_uart: bus registers, TX framing and timing, RX FIFO,
// overrun, framing error, glitch rejection, IRQ and reset abort.
module tb_sbc_uart;
    logic       CLKX4 = 1'b0;
    logic       RESET = 1'b1;
    logic       E = 1'b0, nCSUART = 1'b1, RnW = 1'b1;
    logic [1:0] ADDR = 2'd0;
    logic [7:0] DATA_in = 8'd0;
    logic [7:0] DATA_out;
    logic       DATA_oe, RXD = 1'b1, TXD, nIRQ;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int falls      = 0;
    int fall_log [0:63];
    logic txd_last = 1'b1;

    sbc_uart dut (
        .CLKX4(CLKX4), .RESET(RESET), .E(E), .nCSUART(nCSUART), .RnW(RnW),
        .ADDR(ADDR), .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe),
        .RXD(RXD), .TXD(TXD), .nIRQ(nIRQ)
    );

    always #5 CLKX4 = ~CLKX4;
    always @(posedge CLKX4) cyc <= cyc + 1;

    // Log the cycle of every TXD falling edge seen at a negedge.
    always @(negedge CLKX4) begin
        if (txd_last === 1'b1 && TXD === 1'b0 && falls < 64) begin
            fall_log[falls] <= cyc;
            falls <= falls + 1;
        end
        txd_last <= TXD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic rnw, input logic [7:0] d, output logic [7:0] q);
        E = 1'b1; nCSUART = 1'b0; RnW = rnw; ADDR = a; DATA_in = d;
        @(negedge CLKX4);
        @(negedge CLKX4);
        q = DATA_out;
        check("data_oe", DATA_oe, rnw);
        E = 1'b0; nCSUART = 1'b1; RnW = 1'b1;
        @(negedge CLKX4);
        @(negedge CLKX4);
        $display("bus %s addr=%0d data=%02h", rnw ? "rd" : "wr", a, rnw ? q : d);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        logic [7:0] q;
        bus(a, 1'b0, d, q);
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] q;
        bus(a, 1'b1, 8'h00, q);
        check(tag, q, exp);
    endtask

    task automatic wait_fall(input int base, output int c);
        for (int i = 0; i < 200; i++) begin
            if (falls > base) break;
            @(negedge CLKX4);
        end
        check("tx start seen", falls > base, 1);
        c = (falls > base) ? fall_log[base] : cyc;
    endtask

    task automatic sample_bit(input int target, input logic exp, input string tag);
        if (cyc <= target) begin
            while (cyc < target) @(negedge CLKX4);
            check(tag, TXD, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic check_frames(input int c, input logic [7:0] b0, input logic [7:0] b1, input int nframes);
        logic [7:0] b;
        for (int f = 0; f < nframes; f++) begin
            b = (f == 0) ? b0 : b1;
            for (int i = 0; i < 10; i++) begin
                sample_bit(c + 640*f + 64*i + 3,  frame_bit(b, i), $sformatf("txd f%0d b%0d early", f, i));
                sample_bit(c + 640*f + 64*i + 60, frame_bit(b, i), $sformatf("txd f%0d b%0d late", f, i));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            RXD = (i == 9) ? stop : frame_bit(b, i);
            repeat (64) @(negedge CLKX4);
        end
        RXD = 1'b1;
        repeat (16) @(negedge CLKX4);
        $display("rx sent byte=%02h stop=%0b", b, stop);
    endtask

    initial begin
        int base, c, ok;
        logic [7:0] q;

        repeat (4) @(negedge CLKX4);
        RESET = 1'b0;
        @(negedge CLKX4);

        // Reset state
        check("reset txd", TXD, 1'b1);
        check("reset nirq", nIRQ, 1'b1);
        rd_check(2'd1, 8'h06, "reset status");
        rd_check(2'd2, 8'h00, "reset control");
        rd_check(2'd3, 8'h03, "reset divisor");
        rd_check(2'd0, 8'h00, "empty data");

        // Divisor / control read-back
        wr(2'd3, 8'h07);
        rd_check(2'd3, 8'h07, "divisor rw");
        wr(2'd3, 8'h03);
        wr(2'd2, 8'hFE);
        rd_check(2'd2, 8'h02, "control mask");
        wr(2'd2, 8'h00);

        // Single frame
        base = falls;
        wr(2'd0, 8'hA5);
        wait_fall(base, c);
        check_frames(c, 8'hA5, 8'h00, 1);
        while (cyc < c + 644) @(negedge CLKX4);
        rd_check(2'd1, 8'h06, "status after tx");

        // Back-to-back frames
        base = falls;
        wr(2'd0, 8'h55);
        ok = 0;
        for (int i = 0; i < 40 && ok == 0; i++) begin
            bus(2'd1, 1'b1, 8'h00, q);
            if (q[1]) ok = 1;
        end
        check("txe poll", ok, 1);
        wr(2'd0, 8'hAA);
        wait_fall(base, c);
        check_frames(c, 8'h55, 8'hAA, 2);
        while (cyc < c + 1284) @(negedge CLKX4);
        rd_check(2'd1, 8'h06, "status after b2b");

        // Receive one byte
        send_byte(8'h3C, 1'b1);
        rd_check(2'd1, 8'h07, "rx status avail");
        rd_check(2'd0, 8'h3C, "rx data");
        rd_check(2'd1, 8'h06, "rx status drained");

        // Overrun
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        rd_check(2'd1, 8'h17, "ovr status");
        rd_check(2'd0, 8'h11, "fifo0");
        rd_check(2'd0, 8'h22, "fifo1");
        rd_check(2'd0, 8'h33, "fifo2");
        rd_check(2'd0, 8'h44, "fifo3");
        rd_check(2'd0, 8'h00, "fifo empty");
        rd_check(2'd1, 8'h16, "ovr sticky");
        wr(2'd1, 8'h00);
        rd_check(2'd1, 8'h06, "ovr cleared");

        // Framing error, then glitch rejection
        send_byte(8'h81, 1'b0);
        rd_check(2'd1, 8'h0E, "fe status");
        wr(2'd1, 8'hFF);
        rd_check(2'd1, 8'h06, "fe cleared");
        RXD = 1'b0;
        repeat (4) @(negedge CLKX4);
        RXD = 1'b1;
        repeat (120) @(negedge CLKX4);
        rd_check(2'd1, 8'h06, "glitch ignored");

        // Interrupts
        wr(2'd2, 8'h03);
        check("nirq txie", nIRQ, 1'b0);
        rd_check(2'd1, 8'h86, "irq status");
        wr(2'd2, 8'h01);
        check("nirq rxie empty", nIRQ, 1'b1);
        wr(2'd2, 8'h00);
        check("nirq off", nIRQ, 1'b1);

        // Reset mid-frame
        base = falls;
        wr(2'd0, 8'h00);
        wait_fall(base, c);
        repeat (40) @(negedge CLKX4);
        check("txd mid frame", TXD, 1'b0);
        RESET = 1'b1;
        @(posedge CLKX4);
        #1;
        check("txd after reset edge", TXD, 1'b1);
        @(negedge CLKX4);
        RESET = 1'b0;
        @(negedge CLKX4);
        rd_check(2'd1, 8'h06, "status after reset");
        repeat (200) @(negedge CLKX4);
        check("txd stays idle", TXD, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
